// File: rtl/data2axi4s_pkg.sv
// Shared types and length helpers for the data-to-AXI4-Stream packetizer.
package data2axi4s_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Widest byte-lane count the keep helper supports (1024-bit data).
    localparam int unsigned MAX_BPB = 128;

    function automatic int unsigned bytes_to_beats(input int unsigned bytes, input int unsigned bpb);
        return (bytes + bpb - 1) / bpb;
    endfunction

    function automatic logic [MAX_BPB-1:0] last_keep_mask(input int unsigned bytes, input int unsigned bpb);
        int unsigned rem;
        logic [MAX_BPB-1:0] mask;
        rem = bytes % bpb;
        if (rem == 0) rem = bpb;
        mask = '0;
        for (int unsigned i = 0; i < MAX_BPB; i++) mask[i] = (i < rem);
        return mask;
    endfunction

endpackage

// File: rtl/data2axi4s_pkt_if.sv
// AXI4-Stream bus between the packetizer and its sink.
interface data2axi4s_pkt_if #(
    parameter int DATA_WIDTH = 64
);
    localparam int BPB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] tdata;
    logic [BPB-1:0]        tkeep;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry valid/ready register slice: output register plus one skid entry.
// s_ready comes straight from a flop, so there is no combinational m_ready -> s_ready path.
module axis_skid_buffer #(
    parameter int WIDTH = 73
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             occupied
);
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             push;
    logic             out_free;

    assign s_ready  = !skid_valid;
    assign push     = s_valid && s_ready;
    assign out_free = !m_valid || m_ready;
    assign occupied = m_valid || skid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: payload registers are reset too, so tdata reads 0 straight out of reset.
            m_valid    <= 1'b0;
            m_data     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (out_free) begin
            if (skid_valid) begin
                m_data     <= skid_data;
                m_valid    <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                m_valid <= push;
                if (push) m_data <= s_data;
            end
        end else if (push) begin
            skid_data  <= s_data;
            skid_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/data2axi4s_pkt.sv
// Frames a valid/ready beat stream into AXI4-Stream packets of a runtime byte length,
// with a partial last beat marked by tkeep.
module data2axi4s_pkt
    import data2axi4s_pkg::*;
#(
    parameter  int DATA_WIDTH    = 64,
    parameter  int MAX_PKT_BYTES = 4194304,
    localparam int BPB           = DATA_WIDTH / 8,
    localparam int LEN_W         = $clog2(MAX_PKT_BYTES) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  enable,
    input  logic [LEN_W-1:0]      cfg_pkt_bytes,
    data2axi4s_pkt_if.master      axis,
    output logic [31:0]           pkt_count,
    output logic                  cfg_err,
    output logic                  busy
);
    localparam int WORD_W = DATA_WIDTH + BPB + 1;

    state_t             state;
    logic [LEN_W-1:0]   beat_cnt;
    logic [LEN_W-1:0]   beats_total;
    logic [BPB-1:0]     last_keep;
    logic [LEN_W-1:0]   new_beats;
    logic [BPB-1:0]     new_keep;
    logic               cfg_legal;
    logic               skid_ready;
    logic               skid_busy;
    logic               accept;
    logic               final_beat;
    logic [BPB-1:0]     push_keep;
    logic [WORD_W-1:0]  push_word;
    logic [WORD_W-1:0]  pop_word;
    logic               pop_valid;

    assign cfg_legal  = (cfg_pkt_bytes != '0) && (cfg_pkt_bytes <= LEN_W'(MAX_PKT_BYTES));
    assign new_beats  = LEN_W'(bytes_to_beats(32'(cfg_pkt_bytes), BPB));
    assign new_keep   = BPB'(last_keep_mask(32'(cfg_pkt_bytes), BPB));

    assign in_ready   = (state == RUN) && skid_ready;
    assign accept     = in_valid && in_ready;
    assign final_beat = (beat_cnt == beats_total - LEN_W'(1));
    assign push_keep  = final_beat ? last_keep : '1;
    assign push_word  = {in_data, push_keep, final_beat};
    assign busy       = (state != IDLE) || skid_busy;

    // Length is only sampled at packet boundaries; a legal relatch on the final beat keeps RUN bubble-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            beats_total <= '0;
            last_keep   <= '0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        if (cfg_legal) begin
                            beats_total <= new_beats;
                            last_keep   <= new_keep;
                            beat_cnt    <= '0;
                            state       <= RUN;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (final_beat) begin
                            beat_cnt <= '0;
                            if (enable && cfg_legal) begin
                                beats_total <= new_beats;
                                last_keep   <= new_keep;
                            end else begin
                                state   <= IDLE;
                                cfg_err <= enable;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + LEN_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) pkt_count <= '0;
        else if (axis.tvalid && axis.tready && axis.tlast) pkt_count <= pkt_count + 32'd1;
    end

    axis_skid_buffer #(
        .WIDTH(WORD_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_data  (push_word),
        .s_valid (accept),
        .s_ready (skid_ready),
        .m_data  (pop_word),
        .m_valid (pop_valid),
        .m_ready (axis.tready),
        .occupied(skid_busy)
    );

    assign axis.tvalid = pop_valid;
    assign {axis.tdata, axis.tkeep, axis.tlast} = pop_word;
endmodule

// File: tb/tb_data2axi4s_pkt.sv
// Self-checking bench for data2axi4s_pkt: table vectors, hand-written corner sequences and
// randomized valid/backpressure runs checked against a byte-count packet model.
module tb_data2axi4s_pkt;
    localparam int DW        = 64;
    localparam int BPB       = 8;
    localparam int MAX_BYTES = 4194304;
    localparam int LEN_W     = 23;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        int         bytes;
        int         beats;
        logic [7:0] last_keep;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic              enable;
    logic [LEN_W-1:0]  cfg_pkt_bytes;
    logic [31:0]       pkt_count;
    logic              cfg_err;
    logic              busy;

    data2axi4s_pkt_if #(.DATA_WIDTH(DW)) axis ();

    data2axi4s_pkt #(
        .DATA_WIDTH   (DW),
        .MAX_PKT_BYTES(MAX_BYTES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .enable       (enable),
        .cfg_pkt_bytes(cfg_pkt_bytes),
        .axis         (axis),
        .pkt_count    (pkt_count),
        .cfg_err      (cfg_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int n_acc   = 0;

    beat_t       got[$];
    int          got_cyc[$];
    logic [63:0] sent[$];

    logic        hold_prev = 1'b0;
    logic        full_prev = 1'b0;
    logic [72:0] prev_word = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output/input handshake monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (axis.tvalid && axis.tready) begin
                got.push_back(beat_t'{axis.tdata, axis.tkeep, axis.tlast});
                got_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) sent.push_back(in_data);
            if (hold_prev)
                check("hold_stable", {axis.tvalid, axis.tdata, axis.tkeep, axis.tlast}, {1'b1, prev_word});
            if (full_prev) check("in_ready_drop", in_ready, 1'b0);
            hold_prev <= axis.tvalid && !axis.tready;
            full_prev <= axis.tvalid && !axis.tready && in_valid && in_ready;
            prev_word <= {axis.tdata, axis.tkeep, axis.tlast};
        end else begin
            hold_prev <= 1'b0;
            full_prev <= 1'b0;
        end
    end

    // One clock: handshakes resolve on the rising edge, new stimulus is applied 1 time unit later.
    task automatic cycle();
        logic fire;
        @(negedge clk);
        fire = in_valid && in_ready && !rst;
        @(posedge clk);
        #1;
        if (fire) begin
            in_data = in_data + 64'd1;
            n_acc++;
        end
    endtask

    function automatic beat_t model_beat(input int bytes, input int idx, input logic [63:0] data);
        beat_t b;
        int beats, rem;
        beats  = (bytes + BPB - 1) / BPB;
        rem    = bytes % BPB;
        b.data = data;
        b.last = ((idx % beats) == beats - 1);
        b.keep = 8'hFF;
        if (b.last && rem != 0) b.keep = 8'((1 << rem) - 1);
        return b;
    endfunction

    // Runs npkts back-to-back packets of 'bytes'; mid_bytes >= 0 rewrites the length after beat 2.
    task automatic run_packets(input int bytes, input int npkts, input bit rnd, input int mid_bytes);
        int beats, total;
        logic [31:0] pc0;
        logic busy_seen;
        beats = (bytes + BPB - 1) / BPB;
        total = npkts * beats;
        got.delete();
        got_cyc.delete();
        sent.delete();
        n_acc         = 0;
        pc0           = pkt_count;
        busy_seen     = 1'b0;
        cfg_pkt_bytes = LEN_W'(bytes);
        enable        = 1'b1;
        in_valid      = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        axis.tready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int k = 0; k < 3000; k++) begin
            cycle();
            busy_seen   = busy_seen | busy;
            enable      = (n_acc < (npkts - 1) * beats);
            if (mid_bytes >= 0 && n_acc >= 2) cfg_pkt_bytes = LEN_W'(mid_bytes);
            in_valid    = (n_acc < total) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            axis.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (got.size() >= total) break;
        end
        check("beat_count", got.size(), total);
        if (got.size() >= total) begin
            check("busy_fall", busy, 1'b0);
            check("pkt_count", pkt_count, pc0 + 32'(npkts));
            if (!rnd) check("no_bubble", got_cyc[total-1] - got_cyc[0], total - 1);
        end
        check("busy_seen", busy_seen, 1'b1);
        check("sent_count", sent.size(), total);
        for (int i = 0; i < total; i++) begin
            if (i < got.size() && i < sent.size())
                check($sformatf("beat%0d", i), got[i], model_beat(bytes, i, sent[i]));
        end
        in_valid    = 1'b0;
        axis.tready = 1'b1;
        repeat (4) cycle();
        check("no_extra_beats", got.size(), total);
    endtask

    task automatic cfg_err_case(input logic [LEN_W-1:0] bytes);
        got.delete();
        cfg_pkt_bytes = bytes;
        enable        = 1'b1;
        in_valid      = 1'b1;
        axis.tready   = 1'b1;
        cycle();
        check("cfg_err_pulse", cfg_err, 1'b1);
        check("cfg_err_tvalid", axis.tvalid, 1'b0);
        check("cfg_err_in_ready", in_ready, 1'b0);
        check("cfg_err_busy", busy, 1'b0);
        enable = 1'b0;
        cycle();
        check("cfg_err_clear", cfg_err, 1'b0);
        check("cfg_err_idle_tvalid", axis.tvalid, 1'b0);
        check("cfg_err_no_output", got.size(), 0);
        in_valid = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        int   sz;

        vecs[0] = '{32, 4, 8'hFF};
        vecs[1] = '{20, 3, 8'h0F};
        vecs[2] = '{3,  1, 8'h07};
        vecs[3] = '{8,  1, 8'hFF};
        vecs[4] = '{9,  2, 8'h01};
        vecs[5] = '{1,  1, 8'h01};

        in_data       = 64'd1;
        in_valid      = 1'b0;
        enable        = 1'b0;
        cfg_pkt_bytes = '0;
        axis.tready   = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", axis.tvalid, 1'b0);
        check("rst_tlast", axis.tlast, 1'b0);
        check("rst_tkeep", axis.tkeep, 8'h00);
        check("rst_tdata", axis.tdata, 64'd0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_pkt_count", pkt_count, 32'd0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        cycle();

        // Two back-to-back 32-byte packets, data 1..8, no bubble at the boundary.
        run_packets(32, 2, 1'b0, -1);

        for (int i = 0; i < 6; i++) begin
            run_packets(vecs[i].bytes, 1, 1'b0, -1);
            check("vec_beats", got.size(), vecs[i].beats);
            if (got.size() > 0) begin
                check("vec_last_keep", got[got.size()-1].keep, vecs[i].last_keep);
                check("vec_last_flag", got[got.size()-1].last, 1'b1);
                check("vec_first_keep", got[0].keep, (vecs[i].beats == 1) ? vecs[i].last_keep : 8'hFF);
            end
        end

        cfg_err_case('0);
        cfg_err_case(LEN_W'(MAX_BYTES + 1));

        // 40-byte packet with length and enable changed mid-packet: still 5 beats, then idle.
        run_packets(40, 1, 1'b0, 16);
        sz       = got.size();
        in_valid = 1'b1;
        repeat (8) cycle();
        check("idle_no_output", got.size(), sz);
        check("idle_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;

        run_packets(64, 3, 1'b1, -1);
        run_packets(20, 4, 1'b1, -1);
        run_packets(3, 5, 1'b1, -1);

        // Reset during beat 3 of an 8-beat packet, then a clean full packet.
        got.delete();
        sent.delete();
        n_acc         = 0;
        cfg_pkt_bytes = LEN_W'(64);
        enable        = 1'b1;
        axis.tready   = 1'b1;
        in_valid      = 1'b1;
        cycle();
        enable = 1'b0;
        for (int k = 0; k < 50 && n_acc < 3; k++) cycle();
        check("pre_rst_tvalid", axis.tvalid, 1'b1);
        rst = 1'b1;
        cycle();
        check("mid_rst_tvalid", axis.tvalid, 1'b0);
        check("mid_rst_pkt_count", pkt_count, 32'd0);
        check("mid_rst_busy", busy, 1'b0);
        rst      = 1'b0;
        in_valid = 1'b0;
        cycle();
        run_packets(64, 1, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
